// File: rtl/prover_h_horner_pkg.sv
// Shared prover field definitions.
//   F_NBITS / F_Q : field word width and prime modulus (Goldilocks prime,
//                   2^64 - 2^32 + 1).
//   f_add         : reduced add of two fully reduced field elements.
//   f_reduce      : reduction of a 128-bit product into the field.
//   h_state_t     : FSM state encoding for the H-polynomial Horner stage.
package prover_h_horner_pkg;

    localparam int F_NBITS = 64;
    localparam logic [F_NBITS-1:0] F_Q = 64'hFFFF_FFFF_0000_0001;
    localparam logic [F_NBITS+1:0] F_Q2 = {1'b0, F_Q, 1'b0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MUL,
        ST_ADD,
        ST_DONE
    } h_state_t;

    // Inputs are < F_Q, so the sum is < 2*F_Q and one subtraction suffices.
    function automatic logic [F_NBITS-1:0] f_add(input logic [F_NBITS-1:0] a,
                                                 input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

    // x = h1*2^96 + h0*2^64 + lo with 2^64 = 2^32-1 and 2^96 = -1 (mod F_Q),
    // so x = lo + h0*(2^32-1) - h1. The three non-negative terms sum to
    // less than 3*2^64, which two conditional subtractions bring below F_Q.
    function automatic logic [F_NBITS-1:0] f_reduce(input logic [2*F_NBITS-1:0] x);
        logic [F_NBITS+1:0] s;
        logic [F_NBITS-1:0] lo;
        logic [F_NBITS-1:0] h0_term;
        logic [F_NBITS-1:0] h1_term;
        logic [31:0]        h0;
        logic [31:0]        h1;
        lo      = x[63:0];
        h0      = x[95:64];
        h1      = x[127:96];
        h0_term = {h0, 32'b0} - {32'b0, h0};
        h1_term = F_Q - {32'b0, h1};
        s = {2'b0, lo} + {2'b0, h0_term} + {2'b0, h1_term};
        if (s >= F_Q2) s = s - F_Q2;
        if (s >= {2'b0, F_Q}) s = s - {2'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/prover_h_horner_field_mul_pipe.sv
// field_mul_pipe: fixed-latency modular multiplier, no handshake.
//   clk  : clock
//   a, b : field operands (< F_Q)
//   prod : (a*b) mod F_Q, valid lat cycles after a/b are presented
// The reduction is computed in front of the register chain so that synthesis
// can retime it across the stages. The chain has no reset: stale products
// left in it after a reset are never consumed by the callers.
module field_mul_pipe
    import prover_h_horner_pkg::*;
#(
    parameter int lat = 3
) (
    input  logic               clk,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic [F_NBITS-1:0] prod
);

    logic [2*F_NBITS-1:0] full;
    logic [F_NBITS-1:0]   pipe [lat];

    assign full = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};

    always_ff @(posedge clk) begin
        pipe[0] <= f_reduce(full);
        for (int i = 1; i < lat; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign prod = pipe[lat-1];

endmodule

// File: rtl/prover_h_horner.sv
// prover_h_horner: evaluates H(tau) by Horner's rule over coefficients read
// from the compute stage, highest degree first.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : start pulse, accepted only in IDLE
//   tau          : evaluation point, latched on accepted en
//   p_rden       : coefficient read strobe; p_out valid the following cycle
//   p_out        : coefficient word from upstream
//   h_tau        : H(tau) mod F_Q, held until the next accepted en
//   ready        : high in IDLE
//   ready_pulse  : one-cycle pulse when h_tau is updated
//
// state   | meaning
// IDLE    | waiting for en, ready = 1
// READ    | p_rden = 1 for one cycle
// MUL     | capture coefficient, wait mul_lat cycles for acc*tau
// ADD     | acc <- prod + coef; loop or finish
// DONE    | ready_pulse = 1, h_tau updated
module prover_h_horner
    import prover_h_horner_pkg::*;
#(
    parameter int npoints = 5,
    parameter int mul_lat = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [F_NBITS-1:0] tau,
    output logic               p_rden,
    input  logic [F_NBITS-1:0] p_out,
    output logic [F_NBITS-1:0] h_tau,
    output logic               ready,
    output logic               ready_pulse
);

    localparam int CNT_W  = $clog2(npoints + 1);
    localparam int WAIT_W = $clog2(mul_lat + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(npoints - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(mul_lat - 1);

    h_state_t           state;
    logic [F_NBITS-1:0] tau_q;
    logic [F_NBITS-1:0] acc;
    logic [F_NBITS-1:0] coef_q;
    logic [F_NBITS-1:0] prod;
    logic [F_NBITS-1:0] sum;
    logic [CNT_W-1:0]   cnt;
    logic [WAIT_W-1:0]  wait_cnt;

    // acc and tau_q are constant for the whole MUL state, so the product
    // arriving in ADD is exactly the one issued on the first MUL cycle.
    field_mul_pipe #(
        .lat (mul_lat)
    ) u_mul (
        .clk  (clk),
        .a    (acc),
        .b    (tau_q),
        .prod (prod)
    );

    assign sum = f_add(prod, coef_q);

    // Outputs are registered on the transition into the state that owns
    // them, so they line up with the state and depend on no input directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tau_q       <= '0;
            acc         <= '0;
            coef_q      <= '0;
            cnt         <= '0;
            wait_cnt    <= '0;
            p_rden      <= 1'b0;
            ready       <= 1'b1;
            ready_pulse <= 1'b0;
            h_tau       <= '0;
        end else begin
            p_rden      <= 1'b0;
            ready_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        tau_q  <= tau;
                        acc    <= '0;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        p_rden <= 1'b1;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    wait_cnt <= '0;
                    state    <= ST_MUL;
                end
                ST_MUL: begin
                    if (wait_cnt == '0) coef_q <= p_out;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_ADD;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ADD: begin
                    acc <= sum;
                    if (cnt == CNT_LAST) begin
                        h_tau       <= sum;
                        ready_pulse <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        p_rden <= 1'b1;
                        state  <= ST_READ;
                    end
                end
                ST_DONE: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prover_h_horner.sv
module tb_prover_h_horner;
    import prover_h_horner_pkg::*;

    localparam int NP      = 5;
    localparam int ML      = 3;
    localparam int DONE_AT = 1 + NP * (ML + 2);
    localparam int PERIOD  = DONE_AT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [63:0] tau;
    logic [63:0] p_out;
    logic        p_rden;
    logic [63:0] h_tau;
    logic        ready;
    logic        ready_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] coef_src[$];
    logic [63:0] coef_seen[$];

    always #5 clk = ~clk;

    prover_h_horner #(
        .npoints (NP),
        .mul_lat (ML)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .tau         (tau),
        .p_rden      (p_rden),
        .p_out       (p_out),
        .h_tau       (h_tau),
        .ready       (ready),
        .ready_pulse (ready_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd_fe();
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (v >= F_Q) v = v - F_Q;
        return v;
    endfunction

    // Reference: H(t) = (...((c0*t + c1)*t + c2)...) mod q with wide integers.
    function automatic logic [63:0] horner(input logic [63:0] t, input logic [63:0] c[NP]);
        logic [127:0] h;
        h = '0;
        for (int i = 0; i < NP; i++) begin
            h = (h * {64'b0, t} + {64'b0, c[i]}) % {64'b0, F_Q};
        end
        return h[63:0];
    endfunction

    // Upstream coefficient source: answers each read strobe before the
    // next rising edge, so the word is valid in the cycle after p_rden.
    always @(negedge clk) begin
        if (p_rden === 1'b1) begin
            if (coef_src.size() > 0) p_out = coef_src.pop_front();
            else                     p_out = rnd_fe();
            coef_seen.push_back(p_out);
        end
    end

    task automatic run_eval(input string name, input logic [63:0] t,
                            input logic [63:0] c[NP], input logic [63:0] exp_h,
                            input int glitch_at);
        int          rd_cyc[$];
        int          done_cyc;
        logic [63:0] cf[NP];
        logic [63:0] held;
        coef_src.delete();
        coef_seen.delete();
        for (int i = 0; i < NP; i++) coef_src.push_back(c[i]);
        @(negedge clk);
        tau = t;
        en  = 1'b1;
        done_cyc = -1;
        for (int cyc = 1; cyc <= DONE_AT + 10 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                en = 1'b0;
                chk({name, "_ready_fall"}, {63'b0, ready}, 64'd0);
            end
            if (cyc == glitch_at) begin
                en  = 1'b1;
                tau = rnd_fe();
            end else if (cyc == glitch_at + 1) begin
                en = 1'b0;
            end
            if (p_rden) rd_cyc.push_back(cyc);
            if (ready_pulse) done_cyc = cyc;
        end
        chk({name, "_done_cycle"}, 64'(done_cyc), 64'(DONE_AT));
        chk({name, "_num_reads"}, 64'(rd_cyc.size()), 64'(NP));
        for (int k = 0; k < NP && k < rd_cyc.size(); k++) begin
            chk({name, "_read_cycle"}, 64'(rd_cyc[k]), 64'(1 + k * (ML + 2)));
        end
        chk({name, "_h_tau"}, h_tau, exp_h);
        if (coef_seen.size() >= NP) begin
            for (int i = 0; i < NP; i++) cf[i] = coef_seen[i];
            chk({name, "_h_tau_model"}, h_tau, horner(t, cf));
        end else begin
            chk({name, "_coef_reads"}, 64'(coef_seen.size()), 64'(NP));
        end
        held = h_tau;
        @(negedge clk);
        chk({name, "_ready_rise"}, {63'b0, ready}, 64'd1);
        chk({name, "_pulse_single"}, {63'b0, ready_pulse}, 64'd0);
        chk({name, "_h_tau_held"}, h_tau, held);
    endtask

    initial begin
        logic [63:0] cv[NP];
        logic [63:0] cf[NP];
        logic [63:0] t;
        logic [63:0] tc;
        int          last;
        int          nev;

        rst   = 1'b1;
        en    = 1'b0;
        tau   = '0;
        p_out = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'b0, ready}, 64'd1);
        chk("rst_p_rden", {63'b0, p_rden}, 64'd0);
        chk("rst_pulse", {63'b0, ready_pulse}, 64'd0);
        chk("rst_h_tau", h_tau, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NP; i++) cv[i] = rnd_fe();
        t = rnd_fe();
        run_eval("timing", t, cv, horner(t, cv), -10);

        cv = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        run_eval("zero", 64'd12345, cv, 64'd0, -10);

        cv = '{64'd7, 64'd9, 64'd3, 64'd5, 64'd11};
        run_eval("const_term", 64'd0, cv, 64'd11, -10);

        cv = '{64'd1, 64'd0, 64'd0, 64'd0, 64'd3};
        run_eval("horner_t2", 64'd2, cv, 64'd19, -10);
        run_eval("horner_t1", 64'd1, cv, 64'd4, -10);

        cv = '{F_Q - 64'd1, F_Q - 64'd1, F_Q - 64'd1, F_Q - 64'd1, F_Q - 64'd1};
        run_eval("wrap_all_max", 64'd1, cv, F_Q - 64'd5, -10);

        cv = '{64'd0, 64'd0, 64'd0, 64'd1, 64'd0};
        run_eval("wrap_tau_max", F_Q - 64'd1, cv, F_Q - 64'd1, -10);

        cv = '{64'd1, 64'd0, 64'd0, 64'd0, 64'd3};
        run_eval("en_in_mul", 64'd2, cv, 64'd19, 3);

        // reset in the middle of an evaluation
        coef_src.delete();
        @(negedge clk);
        tau = 64'd77;
        en  = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) en = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst_ready", {63'b0, ready}, 64'd1);
        chk("midrst_p_rden", {63'b0, p_rden}, 64'd0);
        chk("midrst_pulse", {63'b0, ready_pulse}, 64'd0);
        chk("midrst_h_tau", h_tau, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NP; i++) cv[i] = rnd_fe();
        t = rnd_fe();
        run_eval("after_rst", t, cv, horner(t, cv), -10);

        // en held high: back-to-back evaluations on random data
        coef_src.delete();
        coef_seen.delete();
        @(negedge clk);
        tau  = rnd_fe();
        tc   = tau;
        en   = 1'b1;
        last = 0;
        nev  = 0;
        for (int cyc = 1; cyc <= PERIOD * 6 + 20 && nev < 5; cyc++) begin
            @(negedge clk);
            if (ready_pulse) begin
                chk("b2b_gap", 64'(cyc - last), (nev == 0) ? 64'(DONE_AT) : 64'(PERIOD));
                if (coef_seen.size() >= NP) begin
                    for (int i = 0; i < NP; i++) cf[i] = coef_seen.pop_front();
                    chk("b2b_h_tau", h_tau, horner(tc, cf));
                end else begin
                    chk("b2b_coef_reads", 64'(coef_seen.size()), 64'(NP));
                end
                last = cyc;
                nev++;
                tau = rnd_fe();
                tc  = tau;
                if (nev == 5) en = 1'b0;
            end
        end
        en = 1'b0;
        chk("b2b_count", 64'(nev), 64'd5);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
